// File: rtl/cache_refill_ctrl.sv
// Cache line refill sequencer: invalidate, fetch words, write, commit tag.
// Optional CACHE_REFILL_CRITICAL_FIRST_EN: wrap-around order, early restart.
module cache_refill_ctrl #(
  parameter int ADDR_WID   = 32,
  parameter int WORD_WID   = 64,
  parameter int LINE_WORDS = 4,
  parameter int INDEX_WID  = 10,
  localparam int BYTE_OFF  = $clog2(WORD_WID / 8),
  localparam int WORD_OFF  = $clog2(LINE_WORDS),
  localparam int TAG_WID   =
    ADDR_WID - INDEX_WID - WORD_OFF - BYTE_OFF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 miss_valid_i,
  input  logic [ADDR_WID-1:0]  miss_addr_i,
  output logic                 miss_ready_o,
  output logic                 mem_req_o,
  output logic [ADDR_WID-1:0]  mem_addr_o,
  input  logic                 mem_ack_i,
  input  logic [WORD_WID-1:0]  mem_rdata_i,
  output logic                 wr_en_o,
  output logic [INDEX_WID-1:0] wr_index_o,
  output logic [WORD_OFF-1:0]  wr_word_o,
  output logic [WORD_WID-1:0]  wr_data_o,
  output logic                 tag_we_o,
  output logic [TAG_WID-1:0]   tag_o,
  output logic                 tag_valid_o,
  output logic                 crit_valid_o,
  output logic [WORD_WID-1:0]  crit_data_o,
  output logic                 done_o
);

  typedef enum logic [2:0] {
    IDLE, INVAL, REQ, WRITE, COMMIT
  } state_t;

  localparam logic [WORD_OFF:0] N_LAST =
    (WORD_OFF + 1)'(LINE_WORDS - 1);

  state_t               state_q;
  logic [TAG_WID-1:0]   tag_q;
  logic [INDEX_WID-1:0] idx_q;
  logic [WORD_OFF-1:0]  cw_q;
  logic [WORD_OFF:0]    n_q;
  logic [WORD_OFF-1:0]  cur_word;
  logic [WORD_OFF-1:0]  nxt_word;
  logic                 unused_lsb;

  assign unused_lsb = ^miss_addr_i[BYTE_OFF-1:0];

`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
  assign cur_word = cw_q + n_q[WORD_OFF-1:0];
`else
  assign cur_word = n_q[WORD_OFF-1:0];
`endif
  assign nxt_word = cur_word + WORD_OFF'(1);

  // Refill FSM; every output is registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      idx_q        <= '0;
      cw_q         <= '0;
      n_q          <= '0;
      miss_ready_o <= 1'b1;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
      wr_en_o      <= 1'b0;
      wr_index_o   <= '0;
      wr_word_o    <= '0;
      wr_data_o    <= '0;
      tag_we_o     <= 1'b0;
      tag_o        <= '0;
      tag_valid_o  <= 1'b0;
      crit_valid_o <= 1'b0;
      crit_data_o  <= '0;
      done_o       <= 1'b0;
    end else begin
      tag_we_o     <= 1'b0;
      tag_valid_o  <= 1'b0;
      wr_en_o      <= 1'b0;
      crit_valid_o <= 1'b0;
      done_o       <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (miss_valid_i) begin
            tag_q <= miss_addr_i[ADDR_WID-1 -: TAG_WID];
            idx_q <= miss_addr_i[BYTE_OFF+WORD_OFF +: INDEX_WID];
            cw_q  <= miss_addr_i[BYTE_OFF +: WORD_OFF];
            n_q   <= '0;
            tag_o <= miss_addr_i[ADDR_WID-1 -: TAG_WID];
            tag_we_o     <= 1'b1;
            miss_ready_o <= 1'b0;
            state_q      <= INVAL;
          end
        end
        INVAL: begin
          mem_req_o  <= 1'b1;
          mem_addr_o <= {tag_q, idx_q, cur_word,
                         {BYTE_OFF{1'b0}}};
          state_q    <= REQ;
        end
        REQ: begin
          if (mem_ack_i) begin
            mem_req_o  <= 1'b0;
            wr_en_o    <= 1'b1;
            wr_index_o <= idx_q;
            wr_word_o  <= cur_word;
            wr_data_o  <= mem_rdata_i;
            if (cur_word == cw_q) begin
              crit_data_o  <= mem_rdata_i;
`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
              crit_valid_o <= 1'b1;
`endif
            end
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (n_q == N_LAST) begin
            tag_we_o    <= 1'b1;
            tag_valid_o <= 1'b1;
            done_o      <= 1'b1;
`ifndef CACHE_REFILL_CRITICAL_FIRST_EN
            crit_valid_o <= 1'b1;
`endif
            state_q <= COMMIT;
          end else begin
            n_q        <= n_q + (WORD_OFF + 1)'(1);
            mem_req_o  <= 1'b1;
            mem_addr_o <= {tag_q, idx_q, nxt_word,
                           {BYTE_OFF{1'b0}}};
            state_q    <= REQ;
          end
        end
        COMMIT: begin
          miss_ready_o <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          miss_ready_o <= 1'b1;
          mem_req_o    <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl with a random-latency memory.
// Expectations come from an address-arithmetic model of the refill.
module tb_cache_refill_ctrl;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int LW = 4;
  localparam int IW = 10;
  localparam int WO = 2;
  localparam int TW = 17;

`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
  localparam bit CF = 1'b1;
`else
  localparam bit CF = 1'b0;
`endif

  logic          clk;
  logic          rst_i;
  logic          miss_valid_i;
  logic [AW-1:0] miss_addr_i;
  logic          miss_ready_o;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i;
  logic          wr_en_o;
  logic [IW-1:0] wr_index_o;
  logic [WO-1:0] wr_word_o;
  logic [DW-1:0] wr_data_o;
  logic          tag_we_o;
  logic [TW-1:0] tag_o;
  logic          tag_valid_o;
  logic          crit_valid_o;
  logic [DW-1:0] crit_data_o;
  logic          done_o;

  cache_refill_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .miss_valid_i (miss_valid_i),
    .miss_addr_i  (miss_addr_i),
    .miss_ready_o (miss_ready_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .wr_en_o      (wr_en_o),
    .wr_index_o   (wr_index_o),
    .wr_word_o    (wr_word_o),
    .wr_data_o    (wr_data_o),
    .tag_we_o     (tag_we_o),
    .tag_o        (tag_o),
    .tag_valid_o  (tag_valid_o),
    .crit_valid_o (crit_valid_o),
    .crit_data_o  (crit_data_o),
    .done_o       (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [WO-1:0] w;
    logic [DW-1:0] d;
  } wr_t;

  int total = 0;
  int bad = 0;
  int ncyc = 0;
  int cur_delay = 0;
  int mcnt = 0;
  bit stray_en = 0;
  bit junk_en = 0;

  logic [AW-1:0] q_addr[$];
  wr_t           q_wr[$];
  logic [TW:0]   q_tag[$];
  logic [DW-1:0] q_crit[$];
  int            q_done[$];

  function automatic logic [DW-1:0] mem_word(
    input logic [AW-1:0] a);
    return {a ^ 32'hA5A5_5A5A, a * 32'd7 + 32'd1};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h @cyc %0d",
               nm, act, exp, ncyc);
    end
  endtask

  task automatic noexp(input string nm);
    total++;
    bad++;
    $display("FAIL %s: unexpected strobe @cyc %0d",
             nm, ncyc);
  endtask

  // Memory: fixed per-refill latency, stray acks outside requests.
  initial begin
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (mem_req_o === 1'b1) begin
        if (mcnt == cur_delay) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = mem_word(mem_addr_o);
          mcnt = 0;
        end else begin
          mem_ack_i = 1'b0;
          mem_rdata_i = {$urandom, $urandom};
          mcnt++;
        end
      end else begin
        mcnt = 0;
        mem_ack_i = stray_en &&
                    ($urandom_range(0, 3) == 0);
        mem_rdata_i = {$urandom, $urandom};
      end
    end
  end

  // Monitor: pops expectations whenever the DUT strobes.
  initial begin
    logic          prev_req;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] last_crit;
    logic [TW:0]   et;
    wr_t           ew;
    prev_req = 1'b0;
    prev_addr = '0;
    last_crit = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (mem_req_o === 1'b1) begin
        if (prev_req !== 1'b1) begin
          if (q_addr.size() == 0) noexp("mem_req");
          else chk("mem_addr", mem_addr_o,
                   q_addr.pop_front());
        end else begin
          chk("addr_hold", mem_addr_o, prev_addr);
        end
      end
      if (tag_we_o === 1'b1) begin
        if (q_tag.size() == 0) noexp("tag_we");
        else begin
          et = q_tag.pop_front();
          chk("tag", {tag_o, tag_valid_o}, et);
        end
      end
      if (wr_en_o === 1'b1) begin
        if (q_wr.size() == 0) noexp("wr_en");
        else begin
          ew = q_wr.pop_front();
          chk("wr_index", wr_index_o, ew.idx);
          chk("wr_word", wr_word_o, ew.w);
          chk("wr_data", wr_data_o, ew.d);
        end
      end
      if (crit_valid_o === 1'b1) begin
        if (q_crit.size() == 0) noexp("crit_valid");
        else begin
          last_crit = q_crit.pop_front();
          chk("crit_data", crit_data_o, last_crit);
`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
          chk("crit_with_wr", wr_en_o, 1);
`else
          chk("crit_with_done", done_o, 1);
`endif
        end
      end
      if (done_o === 1'b1) begin
        if (q_done.size() == 0) noexp("done");
        else begin
          chk("done_cycle", ncyc, q_done.pop_front());
          chk("crit_hold", crit_data_o, last_crit);
        end
      end
      prev_req = mem_req_o;
      prev_addr = mem_addr_o;
    end
  end

  task automatic wait_idle();
    int w;
    w = 0;
    miss_valid_i = 1'b0;
    do begin
      @(negedge clk);
      #1;
      w++;
    end while (!miss_ready_o && w < 300);
    if (!miss_ready_o) noexp("idle_timeout");
  endtask

  task automatic issue(input logic [AW-1:0] addr,
                       input int dly,
                       output int t0);
    int waited;
    int w;
    logic [WO-1:0] cw;
    logic [AW-1:0] a;
    wr_t e;
    waited = 0;
    t0 = 0;
    forever begin
      @(negedge clk);
      #1;
      if (miss_ready_o) break;
      waited++;
      if (waited > 300) begin
        noexp("ready_timeout");
        miss_valid_i = 1'b0;
        return;
      end
      miss_valid_i = junk_en &&
                     ($urandom_range(0, 2) == 0);
      miss_addr_i = $urandom;
    end
    cur_delay = dly;
    miss_valid_i = 1'b1;
    miss_addr_i = addr;
    t0 = ncyc;
    cw = addr[4:3];
    q_tag.push_back({addr[31:15], 1'b0});
    for (int k = 0; k < LW; k++) begin
      w = CF ? (int'(cw) + k) % LW : k;
      a = {addr[31:5], 2'(w), 3'b000};
      q_addr.push_back(a);
      e.idx = addr[14:5];
      e.w = 2'(w);
      e.d = mem_word(a);
      q_wr.push_back(e);
    end
    q_tag.push_back({addr[31:15], 1'b1});
    q_crit.push_back(mem_word({addr[31:5], cw, 3'b000}));
    q_done.push_back(t0 + 2 + LW * (dly + 2));
    @(posedge clk);
    #1;
    miss_valid_i = 1'b0;
    miss_addr_i = $urandom;
  endtask

  initial begin
    int t0;
    int w;
    rst_i = 1'b1;
    miss_valid_i = 1'b0;
    miss_addr_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_ready", miss_ready_o, 1);
    chk("rst_req", mem_req_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wr_en", wr_en_o, 0);
    chk("rst_wr_data", wr_data_o, 0);
    chk("rst_tag_we", tag_we_o, 0);
    chk("rst_tag", {tag_o, tag_valid_o}, 0);
    chk("rst_crit", {crit_valid_o, done_o}, 0);
    chk("rst_crit_data", crit_data_o, 0);

    issue(32'h0001_2348, 0, t0);
    issue(32'h0001_2348, 3, t0);
    stray_en = 1;
    junk_en = 1;
    issue(32'h0001_2348, 0, t0);
    issue(32'h5A5A_FFF8, 1, t0);

    junk_en = 0;
    issue(32'h0BAD_F00D, 0, t0);
    w = 0;
    while (ncyc < t0 + 7 && w < 50) begin
      @(negedge clk);
      w++;
    end
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    q_addr.delete();
    q_wr.delete();
    q_tag.delete();
    q_crit.delete();
    q_done.delete();
    @(negedge clk);
    #1;
    chk("mid_rst_ready", miss_ready_o, 1);
    chk("mid_rst_strobes",
        {mem_req_o, wr_en_o, tag_we_o, done_o}, 0);
    repeat (4) @(negedge clk);

    junk_en = 1;
    repeat (40) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue($urandom, $urandom_range(0, 3), t0);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("left_addr", q_addr.size(), 0);
    chk("left_wr", q_wr.size(), 0);
    chk("left_tag", q_tag.size(), 0);
    chk("left_crit", q_crit.size(), 0);
    chk("left_done", q_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Line-refill sequencer for the direct-mapped and set-associative cache data/tag stores. On a miss it accepts the missing address, invalidates the target line, fetches the line word by word from main memory over a req/ack handshake, writes each word into the data store, and commits the new tag with valid set. It sits between the cache lookup stage, which raises misses, and the main-memory port.

## Interface
- ADDR_WID, 32, byte address width
- WORD_WID, 64, memory/data-store word width; multiple of 8
- LINE_WORDS, 4, words per line; power of 2, ≥2
- INDEX_WID, 10, line index width
- Derived: BYTE_OFF = log2(WORD_WID/8), WORD_OFF = log2(LINE_WORDS), TAG_WID = ADDR_WID − INDEX_WID − WORD_OFF − BYTE_OFF

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- miss_valid_i  in  1  lookup stage reports a miss
- miss_addr_i  in  ADDR_WID  missing byte address
- miss_ready_o  out  1  controller idle; miss accepted when valid & ready
- mem_req_o  out  1  memory read request
- mem_addr_o  out  ADDR_WID  word-aligned read address (low BYTE_OFF bits 0)
- mem_ack_i  in  1  read data valid this cycle
- mem_rdata_i  in  WORD_WID  read data
- wr_en_o  out  1  data-store word write strobe
- wr_index_o  out  INDEX_WID  line index
- wr_word_o  out  WORD_OFF  word within line
- wr_data_o  out  WORD_WID  word data
- tag_we_o  out  1  tag-store write strobe
- tag_o  out  TAG_WID  tag written
- tag_valid_o  out  1  valid bit written with tag
- crit_valid_o  out  1  requested word available (one-cycle pulse)
- crit_data_o  out  WORD_WID  requested word
- done_o  out  1  refill complete (one-cycle pulse)

## Operation
- States: IDLE, INVAL, REQ, WRITE, COMMIT.
- IDLE: miss_ready_o=1. On miss_valid_i: capture tag, index, critical word index (cw) from miss_addr_i; → INVAL. Later changes on miss_addr_i ignored.
- INVAL: tag_we_o=1, tag_valid_o=0, tag_o=captured tag; word counter n=0; → REQ.
- REQ: mem_req_o=1, mem_addr_o={tag, index, word(n), BYTE_OFF'b0}, held stable until mem_ack_i. On ack: register mem_rdata_i; → WRITE.
- WRITE: wr_en_o=1, wr_index_o=index, wr_word_o=word(n), wr_data_o=registered data. If word(n)==cw, latch data into crit_data_o. If n==LINE_WORDS−1 → COMMIT, else n+1, → REQ.
- COMMIT: tag_we_o=1, tag_valid_o=1, done_o=1; → IDLE.
- word(n) ordering per Configuration; n is WORD_OFF+1 bits, no overflow.
- mem_ack_i outside REQ ignored. miss_valid_i outside IDLE ignored (requester holds).
- Reset (any state, incl. mid-refill): → IDLE next edge; all strobes deassert. Partially filled line stays invalid (INVAL already written); no memory request reissued.

## Timing
- Reset values: miss_ready_o=1 (state IDLE), all other outputs 0.
- All outputs decoded from registered state/data; no combinational path input → output except none.
- Zero-wait memory (ack in first REQ cycle): accept t0, INVAL t1, REQ/WRITE alternate t2..t(2·LINE_WORDS+1), COMMIT t(2·LINE_WORDS+2). LINE_WORDS=4: done_o at t10; miss_ready_o high again t11.
- Each wait cycle on mem_ack_i adds one cycle to REQ.
- Back-to-back misses: next accept no earlier than cycle after COMMIT.

## Configuration
- CACHE_REFILL_CRITICAL_FIRST_EN defined: word(n)=(cw+n) mod LINE_WORDS (wrap-around); crit_valid_o pulses in the first WRITE cycle (early restart), crit_data_o valid from next cycle until next accept.
- Undefined: word(n)=n; crit_valid_o pulses together with done_o, crit_data_o holds word cw from that cycle until next accept.

## Test plan
- Reset then miss 0x0001_2348, zero-wait memory, LINE_WORDS=4 -> tag_we_o/valid=0 at t1; mem_addr_o 0x...2340,48,50,58 (macro off); wr_word_o 0,1,2,3; done_o + tag_valid_o=1 at t10.
- Same miss with CACHE_REFILL_CRITICAL_FIRST_EN -> addresses 0x...2348,50,58,40; crit_valid_o at t3 with data of word 1.
- mem_ack_i delayed 3 cycles per word -> mem_req_o/mem_addr_o stable through wait; done_o at t22.
- miss_valid_i pulsed during REQ and stray mem_ack_i in WRITE -> no second refill, no extra wr_en_o.
- rst_i asserted during third WRITE -> next cycle IDLE, all strobes 0, no done_o, no tag_we_o with valid=1.
- Miss at index 0x3FF, word 3 with macro -> wrap order 3,0,1,2; wr_index_o=0x3FF throughout.
